prog_clk_div: RTL and testbench

PROG_CLK_DIV -- requirements
Module: prog_clk_div

---
 rtl/div_pkg.sv | 17 +
 rtl/clk_div_ch.sv | 80 ++++++++
 rtl/prog_clk_div.sv | 40 ++++
 tb/tb_prog_clk_div.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package div_pkg;

  // Divisor every channel starts from after reset.
  localparam int DEF_DIV_DEFAULT = 5;

  // Divisors below 2 cannot produce a high and a low phase, so they run as 2.
  function automatic logic [31:0] clamp2(input logic [31:0] d);
    return (d < 32'd2) ? 32'd2 : d;
  endfunction

  // Number of high cycles in a divided period: ceil(d/2), no overflow at d=max.
  function automatic logic [31:0] ceil_half(input logic [31:0] d);
    return (d >> 1) + {31'b0, d[0]};
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: phase counter, active/pending divisor, tick counter.
// div_o is a registered data level, never used as a clock.
module clk_div_ch
  import div_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int QW      = 3,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_i,
  input  logic             load,
  output logic             div_o,
  output logic             tick_o,
  output logic [QW-1:0]    q_o,
  output logic             pend_o
);

  localparam logic [WIDTH-1:0] DEF_D = WIDTH'(clamp2(32'(DEF_DIV)));

  logic [WIDTH-1:0] cnt, cnt_nx;
  logic [WIDTH-1:0] d, d_nx, d_apply;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] half_nx;
  logic             wrap;

  // Next phase and divisor; a pending divisor only takes over at the wrap so
  // the running period always completes at its full length.
  always_comb begin
    wrap    = (cnt == d - WIDTH'(1));
    d_apply = pend_o ? WIDTH'(clamp2(32'(p))) : d;
    cnt_nx  = cnt;
    d_nx    = d;
    if (en) begin
      if (wrap) begin
        cnt_nx = '0;
        d_nx   = d_apply;
      end else begin
        cnt_nx = cnt + WIDTH'(1);
      end
    end
    half_nx = WIDTH'(ceil_half(32'(d_nx)));
  end

  // Counter, divisor, output level and tick counter; all frozen while disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      d      <= DEF_D;
      div_o  <= 1'b0;
      tick_o <= 1'b0;
      q_o    <= '0;
    end else if (en) begin
      cnt    <= cnt_nx;
      d      <= d_nx;
      div_o  <= (cnt_nx < half_nx);
      tick_o <= wrap;
      if (wrap) q_o <= q_o + QW'(1);
    end else begin
      tick_o <= 1'b0;
    end
  end

  // Pending divisor capture. A load on the wrap edge wins over the clear, so
  // the value just applied is replaced by the newly loaded one.
  always_ff @(posedge clk) begin
    if (rst) begin
      p      <= '0;
      pend_o <= 1'b0;
    end else if (load) begin
      p      <= div_i;
      pend_o <= 1'b1;
    end else if (en && wrap) begin
      pend_o <= 1'b0;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Multi-channel programmable clock divider; channels are independent and
// the top only slices the shared buses.
module prog_clk_div
  import div_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int WIDTH   = 8,
  parameter int QW      = 3,
  parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] div_i,
  input  logic [NCH-1:0]       load,
  output logic [NCH-1:0]       div_o,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH*QW-1:0]    q_o,
  output logic [NCH-1:0]       pend_o
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    clk_div_ch #(
      .WIDTH  (WIDTH),
      .QW     (QW),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (en[i]),
      .div_i (div_i[i*WIDTH +: WIDTH]),
      .load  (load[i]),
      .div_o (div_o[i]),
      .tick_o(tick_o[i]),
      .q_o   (q_o[i*QW +: QW]),
      .pend_o(pend_o[i])
    );
  end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: behavioural model feeding a
// scoreboard queue, a hand-derived vector table and directed corner cases.
module tb_prog_clk_div;

  localparam int NCH = 2, WIDTH = 8, QW = 3, DEF_DIV = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] div_i;
  logic [NCH-1:0]       load;
  logic [NCH-1:0]       div_o, tick_o, pend_o;
  logic [NCH*QW-1:0]    q_o;

  prog_clk_div #(.NCH(NCH), .WIDTH(WIDTH), .QW(QW), .DEF_DIV(DEF_DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .div_i(div_i), .load(load),
    .div_o(div_o), .tick_o(tick_o), .q_o(q_o), .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0]    div;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    pend;
    logic [NCH*QW-1:0] q;
  } exp_t;

  typedef struct {
    logic       r;
    logic [1:0] e;
    logic [1:0] l;
    logic [7:0] dv0;
    logic       x_div0;
    logic       x_tick0;
    logic       x_pend0;
  } vec_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  int m_cnt[NCH], m_d[NCH], m_p[NCH], m_pend[NCH], m_div[NCH], m_tick[NCH], m_q[NCH];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference behaviour: period of D cycles, high while phase < ceil(D/2).
  task automatic model(input logic r, input logic [NCH-1:0] e, input logic [NCH-1:0] l,
                       input logic [NCH*WIDTH-1:0] dv);
    for (int i = 0; i < NCH; i++) begin
      if (r) begin
        m_cnt[i] = 0; m_d[i] = (DEF_DIV < 2) ? 2 : DEF_DIV; m_p[i] = 0;
        m_pend[i] = 0; m_div[i] = 0; m_tick[i] = 0; m_q[i] = 0;
      end else begin
        if (e[i]) begin
          if (m_cnt[i] == m_d[i] - 1) begin
            if (m_pend[i] != 0) m_d[i] = (m_p[i] < 2) ? 2 : m_p[i];
            m_pend[i] = 0;
            m_cnt[i]  = 0;
            m_q[i]    = (m_q[i] + 1) % (1 << QW);
            m_tick[i] = 1;
          end else begin
            m_cnt[i]++;
            m_tick[i] = 0;
          end
          m_div[i] = (m_cnt[i] < (m_d[i] + 1) / 2) ? 1 : 0;
        end else begin
          m_tick[i] = 0;
        end
        if (l[i]) begin
          m_p[i] = int'(dv[i*WIDTH +: WIDTH]);
          m_pend[i] = 1;
        end
      end
    end
  endtask

  // Drive one cycle, push the model's expectation, compare after the edge.
  task automatic step(input logic r, input logic [NCH-1:0] e, input logic [NCH-1:0] l,
                      input logic [NCH*WIDTH-1:0] dv);
    exp_t x;
    rst = r; en = e; load = l; div_i = dv;
    model(r, e, l, dv);
    for (int i = 0; i < NCH; i++) begin
      x.div[i]  = m_div[i][0];
      x.tick[i] = m_tick[i][0];
      x.pend[i] = m_pend[i][0];
      x.q[i*QW +: QW] = QW'(m_q[i]);
    end
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    chk("sb_div_o",  32'(div_o),  32'(x.div));
    chk("sb_tick_o", 32'(tick_o), 32'(x.tick));
    chk("sb_pend_o", 32'(pend_o), 32'(x.pend));
    chk("sb_q_o",    32'(q_o),    32'(x.q));
  endtask

  function automatic logic [NCH*WIDTH-1:0] dv0(input int v);
    return {8'd0, 8'(v)};
  endfunction

  vec_t tbl[14];
  int   ticks;
  int   found;
  logic d0_hold;
  logic [QW-1:0] q0_hold;

  initial begin
    // Load of 4 at phase 2 of a D=5 period, then D=4 periods (high 2, low 2).
    tbl[0]  = '{1'b1, 2'b00, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 2'b11, 2'b01, 8'd4, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'b11, 2'b00, 8'd0, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; en = '0; load = '0; div_i = '0;

    // Default D=5: first tick on the 5th enabled edge, q wraps after 8 ticks.
    step(1'b1, 2'b00, 2'b00, '0);
    chk("rst_outputs", 32'({div_o, tick_o, pend_o, q_o}), 32'd0);
    ticks = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 2'b11, 2'b00, '0);
      chk("def_tick_pos", 32'(tick_o[0]), 32'((k % 5) == 0));
      chk("def_div_pat", 32'(div_o[0]), 32'(((k % 5) == 0) || ((k % 5) == 1) || ((k % 5) == 2)));
      if (tick_o[0]) begin
        ticks++;
        chk("def_q_count", 32'(q_o[QW-1:0]), 32'(ticks % 8));
      end
    end
    chk("def_q_wrap", 32'(q_o[QW-1:0]), 32'd0);

    // Vector table.
    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].e, tbl[k].l, dv0(int'(tbl[k].dv0)));
      chk("tbl_div0",  32'(div_o[0]),  32'(tbl[k].x_div0));
      chk("tbl_tick0", 32'(tick_o[0]), 32'(tbl[k].x_tick0));
      chk("tbl_pend0", 32'(pend_o[0]), 32'(tbl[k].x_pend0));
    end

    // Loads of 0 then 1 clamp to a period of 2.
    step(1'b0, 2'b11, 2'b01, dv0(0));
    step(1'b0, 2'b11, 2'b01, dv0(1));
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step(1'b0, 2'b11, 2'b00, '0);
      if (tick_o[0]) found = 1;
    end
    chk("clamp_wrap_seen", 32'(found), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b11, 2'b00, '0);
      chk("clamp_div_alt", 32'(div_o[0]), 32'(k % 2));
      chk("clamp_tick_alt", 32'(tick_o[0]), 32'(k % 2));
      chk("clamp_no_x", 32'($isunknown({div_o, tick_o, q_o, pend_o})), 32'd0);
    end

    // Channel 0 enable toggled 1,0,1 every 3 cycles; channel 1 free-running.
    step(1'b1, 2'b00, 2'b00, '0);
    for (int k = 1; k <= 9; k++) begin
      d0_hold = div_o[0];
      q0_hold = q_o[QW-1:0];
      step(1'b0, (k >= 4 && k <= 6) ? 2'b10 : 2'b11, 2'b00, '0);
      if (k >= 4 && k <= 6) begin
        chk("frz_div0", 32'(div_o[0]), 32'(d0_hold));
        chk("frz_q0", 32'(q_o[QW-1:0]), 32'(q0_hold));
      end
      chk("frz_tick0", 32'(tick_o[0]), 32'(k == 8));
      chk("indep_tick1", 32'(tick_o[1]), 32'(k == 5));
    end

    // Reset at phase 3 with a coincident load: load discarded, restart at D=5.
    step(1'b1, 2'b00, 2'b00, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 2'b00, '0);
    step(1'b1, 2'b11, 2'b01, dv0(9));
    chk("rst_mid_outs", 32'({div_o, tick_o, pend_o, q_o}), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 2'b11, 2'b00, '0);
      chk("rst_mid_tick", 32'(tick_o[0]), 32'(k == 5));
    end

    // Load on the wrap edge while another value is pending.
    step(1'b1, 2'b00, 2'b00, '0);
    step(1'b0, 2'b11, 2'b01, dv0(3));
    for (int k = 0; k < 3; k++) step(1'b0, 2'b11, 2'b00, '0);
    step(1'b0, 2'b11, 2'b01, dv0(6));
    chk("wrapld_tick", 32'(tick_o[0]), 32'd1);
    chk("wrapld_pend", 32'(pend_o[0]), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 2'b11, 2'b00, '0);
      chk("wrapld_period", 32'(tick_o[0]), 32'(k == 3 || k == 9));
      chk("wrapld_pend_clr", 32'(pend_o[0]), 32'(k < 3));
    end

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      logic [NCH*WIDTH-1:0] rdv;
      logic [NCH-1:0] rl;
      rdv = {8'($urandom_range(0, 9)), 8'($urandom_range(0, 9))};
      rl  = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
      step(($urandom_range(0, 99) == 0), NCH'($urandom_range(0, 3)), rl, rdv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
